// File: rtl/pwm_sequencer.sv
// Profile sequencer driving the configuration and reset of one pwm instance.
// It plays a small table of profiles in order and counts output pulses to know when to advance.
module pwm_sequencer #(
  parameter int DEPTH   = 4,
  parameter int REP_W   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wrEn,
  input  logic [$clog2(DEPTH)-1:0]   wrAddr,
  input  logic [15:0]                wrPeriod,
  input  logic [7:0]                 wrDuty,
  input  logic                       wrBurst,
  input  logic                       wrType,
  input  logic [REP_W-1:0]           wrReps,
  input  logic [$clog2(DEPTH):0]     numEntries,
  input  logic                       loop,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       pwmIn,
  output logic [15:0]                period,
  output logic [7:0]                 dutyCycle,
  output logic                       modeBurst,
  output logic                       typeBurst,
  output logic                       pwmRst,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH)-1:0]   curIdx
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_NEXT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REP_W-1:0]   rem_q, rem_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               pin_q;
  logic [15:0]        period_q, period_d;
  logic [7:0]         duty_q, duty_d;
  logic               mb_q, mb_d, tb_q, tb_d;
  logic               pwmRst_q, pwmRst_d, busy_q, busy_d, done_q, done_d;

  logic [15:0]        tPeriod_q [DEPTH];
  logic [7:0]         tDuty_q   [DEPTH];
  logic               tBurst_q  [DEPTH];
  logic               tType_q   [DEPTH];
  logic [REP_W-1:0]   tReps_q   [DEPTH];

  logic               rise, found, launch;
  logic [AW-1:0]      nidx;
  logic [CNT_W-1:0]   eff, cnt_use;
  int                 lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tPeriod_q[i] <= '0;
        tDuty_q[i]   <= '0;
        tBurst_q[i]  <= 1'b0;
        tType_q[i]   <= 1'b0;
        tReps_q[i]   <= '0;
      end
    end else if (wrEn && state_q == S_IDLE) begin
      tPeriod_q[wrAddr] <= wrPeriod;
      tDuty_q[wrAddr]   <= (wrDuty > 8'd100) ? 8'd100 : wrDuty;
      tBurst_q[wrAddr]  <= wrBurst;
      tType_q[wrAddr]   <= wrType;
      tReps_q[wrAddr]   <= wrReps;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      rem_q    <= '0;
      gap_q    <= '0;
      pin_q    <= 1'b0;
      period_q <= '0;
      duty_q   <= '0;
      mb_q     <= 1'b0;
      tb_q     <= 1'b0;
      pwmRst_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      pin_q    <= pwmIn;
      period_q <= period_d;
      duty_q   <= duty_d;
      mb_q     <= mb_d;
      tb_q     <= tb_d;
      pwmRst_q <= pwmRst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    period_d = period_q;
    duty_d   = duty_q;
    mb_d     = mb_q;
    tb_d     = tb_q;
    pwmRst_d = pwmRst_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    launch   = 1'b0;
    rise     = pwmIn & ~pin_q;
    eff      = (numEntries > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : numEntries;
    cnt_use  = (state_q == S_IDLE) ? eff : cnt_q;
    lo       = (state_q == S_IDLE) ? 0 : int'(idx_q) + 1;

    // Invalid entries are jumped over in a single step: search forward, then wrap if looping.
    found = 1'b0;
    nidx  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if (!found && j >= lo && j < int'(cnt_use) && tReps_q[j] != '0 && tPeriod_q[j] != '0) begin
        found = 1'b1;
        nidx  = AW'(j);
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (!found && loop && j < int'(cnt_use) && tReps_q[j] != '0 && tPeriod_q[j] != '0) begin
        found = 1'b1;
        nidx  = AW'(j);
      end
    end

    case (state_q)
      S_IDLE: begin
        pwmRst_d = 1'b1;
        busy_d   = 1'b0;
        if (start && eff != '0) begin
          cnt_d  = eff;
          launch = 1'b1;
        end
      end
      S_LOAD: begin
        if (gap_q == '0) begin
          state_d  = S_RUN;
          pwmRst_d = 1'b0;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      S_RUN: begin
        if (rise) begin
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          if (rem_q <= REP_W'(1)) state_d = S_NEXT;
        end
      end
      S_NEXT: launch = 1'b1;
      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        pwmRst_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      busy_d = 1'b1;
      if (found) begin
        state_d  = S_LOAD;
        idx_d    = nidx;
        period_d = tPeriod_q[nidx];
        duty_d   = tDuty_q[nidx];
        mb_d     = tBurst_q[nidx];
        tb_d     = tType_q[nidx];
        rem_d    = tReps_q[nidx];
        gap_d    = GAP_W'(GAP_CYC - 1);
        pwmRst_d = 1'b1;
      end else begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end

    if (stop) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      pwmRst_d = 1'b1;
      done_d   = 1'b0;
    end
  end

  assign period    = period_q;
  assign dutyCycle = duty_q;
  assign modeBurst = mb_q;
  assign typeBurst = tb_q;
  assign pwmRst    = pwmRst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign curIdx    = idx_q;
endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: a cycle-by-cycle vector table for the basic
// sequence plus hand-written sequences for looping, skipping, guards and async reset.
module tb_pwm_sequencer;
  logic        clk = 1'b0;
  logic        rst, wrEn, wrBurst, wrType, loop, start, stop, pwmIn;
  logic [1:0]  wrAddr;
  logic [15:0] wrPeriod;
  logic [7:0]  wrDuty, wrReps;
  logic [2:0]  numEntries;
  logic [15:0] period;
  logic [7:0]  dutyCycle;
  logic        modeBurst, typeBurst, pwmRst, busy, done;
  logic [1:0]  curIdx;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_base;

  pwm_sequencer #(.DEPTH(4), .REP_W(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrPeriod(wrPeriod),
    .wrDuty(wrDuty), .wrBurst(wrBurst), .wrType(wrType), .wrReps(wrReps),
    .numEntries(numEntries), .loop(loop), .start(start), .stop(stop), .pwmIn(pwmIn),
    .period(period), .dutyCycle(dutyCycle), .modeBurst(modeBurst), .typeBurst(typeBurst),
    .pwmRst(pwmRst), .busy(busy), .done(done), .curIdx(curIdx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  typedef struct {
    logic st, sp, pin;
    logic busy, prst, done;
    int   idx, per, duty;
    logic mb, tb;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic step(input logic st, input logic sp, input logic pin);
    start = st; stop = sp; pwmIn = pin;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input int p, input int d, input logic b, input logic t, input int r);
    wrEn = 1'b1; wrAddr = 2'(a); wrPeriod = 16'(p); wrDuty = 8'(d);
    wrBurst = b; wrType = t; wrReps = 8'(r);
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  initial begin
    int reps [2];
    reps[0] = 3; reps[1] = 2;

    //        st sp pin busy prst done idx per  duty mb tb
    vec[0]  = '{1, 0, 0, 1, 1, 0, 0, 1000, 50, 0, 1};
    vec[1]  = '{0, 0, 0, 1, 1, 0, 0, 1000, 50, 0, 1};
    vec[2]  = '{0, 0, 0, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[3]  = '{0, 0, 1, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[4]  = '{0, 0, 1, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[5]  = '{0, 0, 0, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[6]  = '{0, 0, 1, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[7]  = '{0, 0, 0, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[8]  = '{0, 0, 1, 1, 0, 0, 0, 1000, 50, 0, 1};
    vec[9]  = '{0, 0, 0, 1, 1, 0, 1, 2000, 25, 1, 0};
    vec[10] = '{0, 0, 0, 1, 1, 0, 1, 2000, 25, 1, 0};
    vec[11] = '{0, 0, 0, 1, 0, 0, 1, 2000, 25, 1, 0};
    vec[12] = '{0, 0, 1, 1, 0, 0, 1, 2000, 25, 1, 0};
    vec[13] = '{0, 0, 0, 1, 0, 0, 1, 2000, 25, 1, 0};
    vec[14] = '{0, 0, 1, 1, 0, 0, 1, 2000, 25, 1, 0};
    vec[15] = '{0, 0, 0, 1, 0, 1, 1, 2000, 25, 1, 0};
    vec[16] = '{0, 0, 0, 0, 1, 0, 1, 2000, 25, 1, 0};
    vec[17] = '{0, 0, 0, 0, 1, 0, 1, 2000, 25, 1, 0};

    rst = 1'b0; wrEn = 1'b0; wrAddr = '0; wrPeriod = '0; wrDuty = '0; wrBurst = 1'b0;
    wrType = 1'b0; wrReps = '0; numEntries = '0; loop = 1'b0; start = 1'b0; stop = 1'b0;
    pwmIn = 1'b0;
    #2 rst = 1'b1;
    #6;
    chk("rst_pwmRst", int'(pwmRst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_period", int'(period), 0);
    chk("rst_idx", int'(curIdx), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic two-entry sequence
    wr(0, 1000, 50, 1'b0, 1'b1, 3);
    wr(1, 2000, 25, 1'b1, 1'b0, 2);
    numEntries = 3'd2; loop = 1'b0;
    for (int i = 0; i < 18; i++) begin
      step(vec[i].st, vec[i].sp, vec[i].pin);
      chk($sformatf("basic_busy[%0d]", i), int'(busy), int'(vec[i].busy));
      chk($sformatf("basic_pwmRst[%0d]", i), int'(pwmRst), int'(vec[i].prst));
      chk($sformatf("basic_done[%0d]", i), int'(done), int'(vec[i].done));
      chk($sformatf("basic_idx[%0d]", i), int'(curIdx), vec[i].idx);
      chk($sformatf("basic_period[%0d]", i), int'(period), vec[i].per);
      chk($sformatf("basic_duty[%0d]", i), int'(dutyCycle), vec[i].duty);
      chk($sformatf("basic_mb[%0d]", i), int'(modeBurst), int'(vec[i].mb));
      chk($sformatf("basic_tb[%0d]", i), int'(typeBurst), int'(vec[i].tb));
    end
    chk("basic_done_count", done_cnt, 1);

    // Looping with stop
    done_base = done_cnt;
    loop = 1'b1;
    step(1, 0, 0);
    for (int pass = 0; pass < 2; pass++) begin
      for (int e = 0; e < 2; e++) begin
        chk($sformatf("loop_idx[%0d.%0d]", pass, e), int'(curIdx), e);
        chk($sformatf("loop_load_rst[%0d.%0d]", pass, e), int'(pwmRst), 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk($sformatf("loop_run_rst[%0d.%0d]", pass, e), int'(pwmRst), 0);
        for (int k = 0; k < reps[e]; k++) begin
          step(0, 0, 1);
          step(0, 0, 0);
        end
      end
    end
    chk("loop_wrap_idx", int'(curIdx), 0);
    chk("loop_wrap_busy", int'(busy), 1);
    step(0, 1, 0);
    chk("loop_stop_busy", int'(busy), 0);
    chk("loop_stop_rst", int'(pwmRst), 1);
    step(0, 0, 0);
    chk("loop_stop_stays", int'(busy), 0);
    chk("loop_no_done", done_cnt, done_base);

    // Skip invalid entries, duty clamp, and guards while busy
    loop = 1'b0;
    wr(0, 1000, 50, 1'b0, 1'b0, 1);
    wr(1, 3000, 60, 1'b0, 1'b0, 0);
    wr(2, 0, 70, 1'b0, 1'b0, 2);
    wr(3, 4000, 150, 1'b1, 1'b1, 1);
    numEntries = 3'd4;
    step(1, 0, 0);
    chk("skip_idx0", int'(curIdx), 0);
    step(0, 0, 0);
    step(0, 0, 0);
    wrEn = 1'b1; wrAddr = 2'd3; wrPeriod = 16'd9999; wrDuty = 8'd10; wrReps = 8'd5;
    step(0, 0, 0);
    wrEn = 1'b0;
    step(1, 0, 0);
    chk("busy_start_idx", int'(curIdx), 0);
    chk("busy_start_rst", int'(pwmRst), 0);
    chk("busy_start_busy", int'(busy), 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("skip_idx3", int'(curIdx), 3);
    chk("skip_duty_clamp", int'(dutyCycle), 100);
    chk("skip_period_kept", int'(period), 4000);
    chk("skip_load_rst", int'(pwmRst), 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("skip_done", int'(done), 1);
    step(0, 0, 0);
    chk("skip_idle_busy", int'(busy), 0);
    chk("skip_idle_done", int'(done), 0);

    // start with zero count, and start+stop together
    numEntries = 3'd0;
    step(1, 0, 0);
    chk("zero_cnt_busy", int'(busy), 0);
    chk("zero_cnt_rst", int'(pwmRst), 1);
    numEntries = 3'd4;
    step(1, 1, 0);
    chk("start_stop_busy", int'(busy), 0);
    step(0, 0, 0);
    chk("start_stop_idle", int'(busy), 0);

    // Asynchronous reset in the middle of RUN on entry 3
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_arst_idx", int'(curIdx), 3);
    chk("pre_arst_rst", int'(pwmRst), 0);
    #3 rst = 1'b1;
    #1;
    chk("arst_pwmRst", int'(pwmRst), 1);
    chk("arst_period", int'(period), 0);
    chk("arst_duty", int'(dutyCycle), 0);
    chk("arst_mb", int'(modeBurst), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_idx", int'(curIdx), 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    numEntries = 3'd1;
    step(1, 0, 0);
    chk("arst_empty_busy", int'(busy), 1);
    chk("arst_empty_done", int'(done), 1);
    step(0, 0, 0);
    chk("arst_empty_done_end", int'(done), 0);
    chk("arst_empty_idle", int'(busy), 0);
    chk("arst_empty_rst", int'(pwmRst), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
